qtr_emu: RTL and testbench
==========================

Name: qtr_emu

Overview:
- Synthesizable emulator for the far end of the QTR reflectance-sensor pin protocol.
- Observes the host-side QTR pin controls (drive enable, drive level, IR ctrl) and returns the decaying sense line the host samples.
- Used in loopback builds and benches in place of a physical Pololu QTR. Decay time is programmed in 10 us units, matching the host's 8-bit result resolution.

Parameters:
- CLK_FREQUENCY, 60_000_000, hba_clk frequency in Hz.
- CHARGE_MIN_US, 10, minimum continuous host drive-high time that counts as a valid charge.
- TICK_CYCLES, CLK_FREQUENCY/100_000, derived: clocks per 10 us decay unit.
- CHARGE_CYCLES, CLK_FREQUENCY/1_000_000*CHARGE_MIN_US, derived: clocks of drive-high needed.

Ports:
- hba_clk  input  1  single clock.
- hba_reset  input  1  synchronous, active-low reset (0 = reset).
- host_out_en  input  1  host is driving the sensor pin.
- host_out_sig  input  1  level the host drives.
- host_ctrl  input  1  host IR-LED enable.
- decay_value  input  8  reflectance value to emulate, in 10 us units.
- emu_sig  output  1  pin level returned to the host (host qtr_in_sig).
- busy  output  1  high while in CHARGED or DECAY.
- done  output  1  one-cycle pulse when a decay completes.
- short_charge  output  1  one-cycle pulse when the host releases before a valid charge.

Behaviour:
- Reset (hba_reset==0 at a clock edge): state=IDLE, all counters 0. Outputs emu_sig=0, busy=0, done=0, short_charge=0.
- emu_sig is registered.
- Whenever host_out_en==1, emu_sig follows host_out_sig with 1 cycle latency, in every state.
- States:
  - IDLE: emu_sig=0.
    - host_out_en & host_out_sig → CHARGING, charge_cnt=1.
  - CHARGING: charge_cnt increments each cycle while host_out_en & host_out_sig, saturating at CHARGE_CYCLES.
    - charge_cnt reaches CHARGE_CYCLES → CHARGED.
    - host_out_sig drops while host_out_en=1 → IDLE, no pulse.
    - host_out_en drops before charged → IDLE; short_charge pulses 1 cycle; emu_sig=0 next cycle.
  - CHARGED: busy=1.
    - host drives low → IDLE.
    - host_out_en falls at edge N → DECAY.
      - Latch eff = host_ctrl ? decay_value : 8'hFF, sampled at edge N.
      - Clear tick_cnt and unit_cnt.
  - DECAY: emu_sig=1, busy=1.
    - tick_cnt counts 0..TICK_CYCLES-1 and wraps; unit_cnt increments on each wrap.
    - When unit_cnt==eff: emu_sig=0, done pulses, → IDLE.
- Timing:
  - emu_sig high from edge N+1 through edge N+eff*TICK_CYCLES.
  - emu_sig low at edge N+eff*TICK_CYCLES+1; done pulses in that same cycle.
  - eff==0: emu_sig high for 0 cycles; low at N+1; done at N+1.
  - eff==255: 255*TICK_CYCLES high cycles (2.55 ms).
- Mid-decay events:
  - decay_value and host_ctrl changes during DECAY are ignored; eff is held.
  - host_out_en rises during DECAY → abort with no done. emu_sig follows host. If host_out_sig=1 → CHARGING (charge_cnt=1), else IDLE.
  - Simultaneous decay completion and host_out_en rise: the host re-drive wins and done is suppressed.
- Reset mid-operation returns to IDLE within the same edge, with no done or short_charge pulse.

Optional Feature:
- Macro QTR_EMU_JITTER_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advances once per entry to DECAY.
  - eff = min(255, base + lfsr[1:0]), where base = host_ctrl ? decay_value : 8'hFF. Models 0–3 units of sensor noise.
- Undefined: no LFSR logic; eff is exact.
- All Test Plan values assume the macro is undefined.

Test Plan:
- CLK_FREQUENCY=1_000_000 (TICK=10, CHARGE=10), decay_value=8'h20, host_ctrl=1. Drive 12 cycles high, release at edge N → emu_sig high N+1..N+320, low at N+321; done pulses once at N+321.
- Same setup, drive high only 5 cycles then release → short_charge pulses once; emu_sig=0 next cycle; busy never asserts; no done.
- host_ctrl=0, decay_value=8'h05, valid charge → emu_sig high 2550 cycles (eff=8'hFF).
- decay_value=0, valid charge, release at N → emu_sig low at N+1, done at N+1.
- decay_value=8'h40; at 100 cycles into DECAY, reassert host_out_en with host_out_sig=1 → no done, state CHARGING; then change decay_value to 8'h03 mid-decay → change has no effect (eff stays 8'h40).
- hba_reset driven 0 for 1 cycle at 50 cycles into DECAY → next cycle emu_sig=0, busy=0, no done or short_charge pulse.

Source files
------------

// File: rtl/qtr_emu_if.sv
// ============================================================================
// Module      : qtr_emu_if
// Description : Host-side QTR pin controls and the emulated sense-line
//               returns, grouped for connection to qtr_emu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qtr_emu_if;
  logic       host_out_en;   // host is driving the sensor pin
  logic       host_out_sig;  // level the host drives
  logic       host_ctrl;     // host IR-LED enable
  logic [7:0] decay_value;   // emulated reflectance, 10 us units
  logic       emu_sig;       // pin level returned to the host
  logic       busy;          // CHARGED or DECAY in progress
  logic       done;          // one-cycle pulse at decay completion
  logic       short_charge;  // one-cycle pulse on an aborted charge

  // Host side: drives pin controls, observes the emulated pin
  modport master (
    output host_out_en, host_out_sig, host_ctrl, decay_value,
    input  emu_sig, busy, done, short_charge
  );

  // Emulator side
  modport slave (
    input  host_out_en, host_out_sig, host_ctrl, decay_value,
    output emu_sig, busy, done, short_charge
  );
endinterface

`default_nettype wire

// File: rtl/qtr_emu.sv
// ============================================================================
// Module      : qtr_emu
// Description : Far-end emulator of the QTR reflectance-sensor pin protocol.
//               Watches the host charge the pin, then holds the sense line
//               high for a programmed number of 10 us units once released.
//               Optional macro QTR_EMU_JITTER_EN adds 0-3 units of LFSR
//               noise to each decay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qtr_emu #(
  parameter int CLK_FREQUENCY = 60_000_000,
  parameter int CHARGE_MIN_US = 10
) (
  input  logic      hba_clk,
  input  logic      hba_reset,   // synchronous, active-low
  qtr_emu_if.slave  bus
);

  // Derived timing: clocks per 10 us decay unit and clocks of valid charge
  localparam int TICK_CYCLES   = CLK_FREQUENCY / 100_000;
  localparam int CHARGE_CYCLES = CLK_FREQUENCY / 1_000_000 * CHARGE_MIN_US;

  localparam int TICK_W = (TICK_CYCLES > 1)   ? $clog2(TICK_CYCLES)       : 1;
  localparam int CHG_W  = (CHARGE_CYCLES > 0) ? $clog2(CHARGE_CYCLES + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [CHG_W-1:0]  CHG_MAX   = CHG_W'(CHARGE_CYCLES);
  localparam logic [CHG_W-1:0]  CHG_ONE   = CHG_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHARGING = 2'd1,
    S_CHARGED  = 2'd2,
    S_DECAY    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CHG_W-1:0]  charge_cnt_q, charge_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        unit_cnt_q, unit_cnt_d;
  logic [7:0]        eff_q, eff_d;
  logic              emu_sig_q, emu_sig_d;
  logic              done_q, done_d;
  logic              short_q, short_d;

  logic              enter_decay;
  logic [7:0]        eff_new;
  logic [7:0]        base;

  wire drive_hi = bus.host_out_en & bus.host_out_sig;

  // With IR off the pin never sees reflected light: full-scale decay
  assign base = bus.host_ctrl ? bus.decay_value : 8'hFF;

`ifdef QTR_EMU_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [8:0] jit_sum;

  // Noisy decay length, saturated to the 8-bit range; LFSR steps once per decay
  always_comb begin
    jit_sum = {1'b0, base} + {7'b0, lfsr_q[1:0]};
    eff_new = jit_sum[8] ? 8'hFF : jit_sum[7:0];
    lfsr_d  = lfsr_q;
    if (enter_decay) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // LFSR register, seeded on reset
  always_ff @(posedge hba_clk) begin
    if (!hba_reset) lfsr_q <= 8'hA5;
    else            lfsr_q <= lfsr_d;
  end
`else
  assign eff_new = base;
`endif

  // Next-state and output decode; a host drive always overrides the pin level
  always_comb begin
    state_d      = state_q;
    charge_cnt_d = charge_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    unit_cnt_d   = unit_cnt_q;
    eff_d        = eff_q;
    emu_sig_d    = 1'b0;
    done_d       = 1'b0;
    short_d      = 1'b0;
    enter_decay  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (drive_hi) begin
          charge_cnt_d = CHG_ONE;
          state_d      = (CHG_MAX <= CHG_ONE) ? S_CHARGED : S_CHARGING;
        end
      end

      S_CHARGING: begin
        if (drive_hi) begin
          if (charge_cnt_q < CHG_MAX) charge_cnt_d = charge_cnt_q + CHG_ONE;
          if (charge_cnt_q >= CHG_MAX - CHG_ONE) state_d = S_CHARGED;
        end else if (bus.host_out_en) begin
          // host pulled the pin low: not a charge attempt, no pulse
          charge_cnt_d = '0;
          state_d      = S_IDLE;
        end else begin
          // released too early to have charged the capacitor
          charge_cnt_d = '0;
          short_d      = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_CHARGED: begin
        if (!bus.host_out_en) begin
          // release edge: freeze the decay length and start timing
          eff_d        = eff_new;
          tick_cnt_d   = '0;
          unit_cnt_d   = '0;
          charge_cnt_d = '0;
          emu_sig_d    = 1'b1;
          enter_decay  = 1'b1;
          state_d      = S_DECAY;
        end else if (!bus.host_out_sig) begin
          charge_cnt_d = '0;
          state_d      = S_IDLE;
        end
      end

      S_DECAY: begin
        if (bus.host_out_en) begin
          // host re-drive aborts the decay and takes priority over completion
          charge_cnt_d = bus.host_out_sig ? CHG_ONE : '0;
          if (!bus.host_out_sig)        state_d = S_IDLE;
          else if (CHG_MAX <= CHG_ONE)  state_d = S_CHARGED;
          else                          state_d = S_CHARGING;
        end else if (unit_cnt_q == eff_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          emu_sig_d = 1'b1;
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            unit_cnt_d = unit_cnt_q + 8'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.host_out_en) emu_sig_d = bus.host_out_sig;
  end

  // State, counters and registered outputs
  always_ff @(posedge hba_clk) begin
    if (!hba_reset) begin
      state_q      <= S_IDLE;
      charge_cnt_q <= '0;
      tick_cnt_q   <= '0;
      unit_cnt_q   <= '0;
      eff_q        <= '0;
      emu_sig_q    <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      charge_cnt_q <= charge_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      unit_cnt_q   <= unit_cnt_d;
      eff_q        <= eff_d;
      emu_sig_q    <= emu_sig_d;
      done_q       <= done_d;
      short_q      <= short_d;
    end
  end

  assign bus.emu_sig      = emu_sig_q;
  assign bus.busy         = (state_q == S_CHARGED) || (state_q == S_DECAY);
  assign bus.done         = done_q;
  assign bus.short_charge = short_q;

endmodule

`default_nettype wire

// File: tb/tb_qtr_emu.sv
// ============================================================================
// Module      : tb_qtr_emu
// Description : Directed bench for qtr_emu at 1 MHz (10 clocks per decay
//               unit, 10 clocks of valid charge).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qtr_emu;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  qtr_emu_if bus();

  qtr_emu #(
    .CLK_FREQUENCY (1_000_000),
    .CHARGE_MIN_US (10)
  ) dut (
    .hba_clk   (clk),
    .hba_reset (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hold the pin high for n edges, then set up the release for the next edge
  task automatic charge(input int n, output int busy_seen);
    busy_seen = 0;
    bus.host_out_en  = 1'b1;
    bus.host_out_sig = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.busy) busy_seen = 1;
    end
    bus.host_out_en  = 1'b0;
    bus.host_out_sig = 1'b0;
  endtask

  // watch up to budget edges; report first low edge and pulse activity
  task automatic watch(input int budget, output int low_at, output int dn_cnt,
                       output int dn_at, output int sc_cnt);
    low_at = -1; dn_cnt = 0; dn_at = -1; sc_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (!bus.emu_sig && low_at < 0) low_at = k;
      if (bus.done) begin dn_cnt++; dn_at = k; end
      if (bus.short_charge) sc_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int bs, low_at, dn_cnt, dn_at, sc_cnt;

    bus.host_out_en  = 1'b0;
    bus.host_out_sig = 1'b0;
    bus.host_ctrl    = 1'b1;
    bus.decay_value  = 8'h20;

    // reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst_emu",   bus.emu_sig,      0);
    chk("rst_busy",  bus.busy,         0);
    chk("rst_done",  bus.done,         0);
    chk("rst_short", bus.short_charge, 0);
    rst_n = 1'b1;
    step();

    // valid charge, eff = 0x20 -> low and done at N+321
    charge(12, bs);
    chk("t1_busy_charged", bus.busy, 1);
    step();
    chk("t1_emu_after_N",  bus.emu_sig, 1);
    chk("t1_busy_decay",   bus.busy,    1);
    watch(340, low_at, dn_cnt, dn_at, sc_cnt);
    chk("t1_low_at",  low_at, 321);
    chk("t1_done_at", dn_at,  321);
    chk("t1_done_n",  dn_cnt, 1);
    chk("t1_busy_end", bus.busy, 0);

    // short charge: 5 cycles only
    charge(5, bs);
    chk("t2_busy_seen", bs, 0);
    step();
    chk("t2_short", bus.short_charge, 1);
    chk("t2_emu",   bus.emu_sig,      0);
    chk("t2_busy",  bus.busy,         0);
    watch(30, low_at, dn_cnt, dn_at, sc_cnt);
    chk("t2_short_once", sc_cnt, 0);
    chk("t2_no_done",    dn_cnt, 0);

    // IR off -> full-scale decay regardless of decay_value
    bus.host_ctrl   = 1'b0;
    bus.decay_value = 8'h05;
    charge(12, bs);
    step();
    watch(2570, low_at, dn_cnt, dn_at, sc_cnt);
    chk("t3_low_at",  low_at, 2551);
    chk("t3_done_n",  dn_cnt, 1);

    // zero decay: low and done one edge after release
    bus.host_ctrl   = 1'b1;
    bus.decay_value = 8'h00;
    charge(12, bs);
    step();
    watch(20, low_at, dn_cnt, dn_at, sc_cnt);
    chk("t4_low_at",  low_at, 1);
    chk("t4_done_at", dn_at,  1);
    chk("t4_done_n",  dn_cnt, 1);

    // zero decay with re-drive low on the completion edge: done suppressed
    charge(12, bs);
    step();
    bus.host_out_en  = 1'b1;
    bus.host_out_sig = 1'b0;
    step();
    chk("t4b_done", bus.done,    0);
    chk("t4b_emu",  bus.emu_sig, 0);
    chk("t4b_busy", bus.busy,    0);
    bus.host_out_en = 1'b0;
    step();
    chk("t4b_done_late", bus.done, 0);

    // abort at 100 cycles into decay by re-driving high
    bus.decay_value = 8'h40;
    charge(12, bs);
    step();
    repeat (99) step();
    bus.host_out_en  = 1'b1;
    bus.host_out_sig = 1'b1;
    step();
    chk("t5_emu_follow", bus.emu_sig, 1);
    chk("t5_busy_chg",   bus.busy,    0);
    chk("t5_done",       bus.done,    0);
    // this drive continues into a full charge (12 high edges total)
    charge(11, bs);
    chk("t5_recharged", bus.busy, 1);
    step();
    repeat (10) step();
    bus.decay_value = 8'h03;
    bus.host_ctrl   = 1'b0;
    watch(650, low_at, dn_cnt, dn_at, sc_cnt);
    chk("t5_eff_held_low", low_at, 631);
    chk("t5_done_n",       dn_cnt, 1);

    // reset at 50 cycles into decay
    bus.host_ctrl   = 1'b1;
    bus.decay_value = 8'h20;
    charge(12, bs);
    step();
    repeat (49) step();
    rst_n = 1'b0;
    step();
    chk("t6_emu",   bus.emu_sig,      0);
    chk("t6_busy",  bus.busy,         0);
    chk("t6_done",  bus.done,         0);
    chk("t6_short", bus.short_charge, 0);
    rst_n = 1'b1;
    watch(400, low_at, dn_cnt, dn_at, sc_cnt);
    chk("t6_stay_low", low_at, 1);
    chk("t6_no_done",  dn_cnt, 0);
    chk("t6_no_short", sc_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
